btn_debounce_multi: RTL and testbench

Parametrised multi-channel button debouncer with counter-based stability filtering, per-channel press/release strobes and optional auto-repeat. Each raw asynchronous button/switch input is synchronised, filtered until stable for a programmable number of clocks, and converted into a clean level plus single-cycle event pulses. It sits between board push-buttons/switches and the lab control logic, replacing the bare two-flop edge detector for multi-button front panels.

---
 rtl/btn_debounce_multi.sv | 118 +++++++++++
 tb/tb_btn_debounce_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel debouncer: 2-flop sync, stability counter, press/release/auto-repeat strobes.
// Latency STABLE_CYCLES+2 clocks from raw input to state/strobe; no backpressure, strobes are fire-and-forget.
module btn_debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] state_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] repeat_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] w_norm;
  logic [CHANNELS-1:0] r_sync0;
  logic [CHANNELS-1:0] r_sync1;

  assign w_norm = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= w_norm;
      r_sync1 <= r_sync0;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync1[ch] ^ r_state;
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    // Any cycle where the synchronised input agrees with the filtered state restarts the count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_cnt     <= '0;
        r_state   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_done &  r_sync1[ch];
        r_release <= w_done & ~r_sync1[ch];
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_done) begin
          r_cnt   <= '0;
          r_state <= r_sync1[ch];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign state_o[ch]   = r_state;
    assign press_o[ch]   = r_press;
    assign release_o[ch] = r_release;

    if (REPEAT_EN != 0) begin : g_rep
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
      localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] r_rcnt;
      logic          r_first;
      logic          r_rep;
      logic          w_rel_evt;

      assign w_rel_evt = w_done & ~r_sync1[ch];

      // The press edge lands in the !r_state branch, which arms the delay phase.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_rcnt  <= '0;
          r_first <= 1'b1;
          r_rep   <= 1'b0;
        end else begin
          r_rep <= 1'b0;
          if (!r_state || w_rel_evt) begin
            r_rcnt  <= '0;
            r_first <= 1'b1;
          end else if (r_first && (r_rcnt == DLY_LAST)) begin
            r_rep   <= 1'b1;
            r_rcnt  <= '0;
            r_first <= 1'b0;
          end else if (!r_first && (r_rcnt == PER_LAST)) begin
            r_rep  <= 1'b1;
            r_rcnt <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
      end

      assign repeat_o[ch] = r_rep;
    end else begin : g_norep
      assign repeat_o[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed literal checks plus randomized toggles vs a window/elapsed-time model.
module tb_btn_debounce_multi;
  localparam int CH  = 2;
  localparam int S   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [CH-1:0] btn = 2'b00;
  logic [CH-1:0] state_o, press_o, release_o, repeat_o;

  int errors = 0;
  int checks = 0;

  btn_debounce_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(S), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(btn),
    .state_o(state_o), .press_o(press_o), .release_o(release_o), .repeat_o(repeat_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last S synchronised samples all disagree with it;
  // repeats are judged from the elapsed clocks since the press strobe.
  int            cyc = 0;
  logic [CH-1:0] d1 = '0, d2 = '0;
  logic [CH-1:0] m_state = '0, m_press = '0, m_rel = '0, m_rep = '0;
  logic [S-1:0]  hist [CH];
  int            hlen [CH];
  int            ptime [CH];

  task automatic model_reset();
    d1 = '0; d2 = '0;
    m_state = '0; m_press = '0; m_rel = '0; m_rep = '0;
    for (int c = 0; c < CH; c++) begin
      hist[c] = '0; hlen[c] = 0; ptime[c] = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] nnow);
    logic         s, flip, rep;
    logic [S-1:0] ones, want;
    int           e;
    cyc++;
    ones = '1;
    for (int c = 0; c < CH; c++) begin
      s = d2[c];
      hist[c] = {hist[c][S-2:0], s};
      if (hlen[c] < S) hlen[c]++;
      want = m_state[c] ? '0 : ones;
      flip = (hlen[c] == S) && (hist[c] == want);
      rep = 1'b0;
      if (m_state[c] && !flip) begin
        e = cyc - ptime[c];
        rep = (e == DLY) || ((e > DLY) && ((e - DLY) % PER == 0));
      end
      m_press[c] = flip && s;
      m_rel[c]   = flip && !s;
      m_rep[c]   = rep;
      if (flip) begin
        m_state[c] = s;
        if (s) ptime[c] = cyc;
      end
    end
    d2 = d1;
    d1 = nnow;
  endtask

  initial begin
    logic [CH-1:0] nnow;
    logic          rstv;
    model_reset();
    forever begin
      @(posedge clk_i);
      nnow = ~btn;
      rstv = rst_n_i;
      #1;
      if (!rstv) model_reset();
      else model_step(nnow);
      chk("model_state",   state_o,   m_state);
      chk("model_press",   press_o,   m_press);
      chk("model_release", release_o, m_rel);
      chk("model_repeat",  repeat_o,  m_rep);
    end
  end

  task automatic edge_();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    int e;
    rst_n_i = 1'b0;
    btn = 2'b00;
    repeat (3) edge_();
    chk("rst_state",   state_o,   2'b00);
    chk("rst_press",   press_o,   2'b00);
    chk("rst_release", release_o, 2'b00);
    chk("rst_repeat",  repeat_o,  2'b00);

    rst_n_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_();
      chk("pwrup_press", press_o, (k == 6) ? 2'b11 : 2'b00);
      if (k >= 6) chk("pwrup_state", state_o, 2'b11);
    end

    for (int k = 8; k <= 30; k++) begin
      edge_();
      e = k - 6;
      chk("rep_seq", repeat_o,
          (e == 10 || e == 13 || e == 16 || e == 19 || e == 22) ? 2'b11 : 2'b00);
    end

    btn = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      edge_();
      chk("rel_ch0", release_o, (j == 6) ? 2'b01 : 2'b00);
    end
    chk("rel_state", state_o, 2'b10);

    repeat (4) edge_();
    btn[0] = 1'b0; repeat (3) edge_();
    btn[0] = 1'b1; repeat (1) edge_();
    btn[0] = 1'b0; repeat (3) edge_();
    btn[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      edge_();
      chk("bounce_press0", {1'b0, press_o[0]}, 2'b00);
      chk("bounce_state0", {1'b0, state_o[0]}, 2'b00);
    end

    btn[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      edge_();
      chk("clean_press0",   {1'b0, press_o[0]},   (k == 6)  ? 2'b01 : 2'b00);
      chk("clean_release0", {1'b0, release_o[0]}, (k == 26) ? 2'b01 : 2'b00);
      chk("clean_state0",   {1'b0, state_o[0]},   (k >= 6 && k < 26) ? 2'b01 : 2'b00);
      chk("clean_repeat0",  {1'b0, repeat_o[0]},
          (k == 16 || k == 19 || k == 22 || k == 25) ? 2'b01 : 2'b00);
      if (k == 20) btn[0] = 1'b1;
    end

    repeat (3) edge_();
    btn[0] = 1'b0;
    repeat (4) edge_();
    rst_n_i = 1'b0;
    #1;
    chk("arst_state",   state_o,   2'b00);
    chk("arst_press",   press_o,   2'b00);
    chk("arst_release", release_o, 2'b00);
    chk("arst_repeat",  repeat_o,  2'b00);
    edge_();
    edge_();
    rst_n_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_();
      chk("arst_repress", press_o, (k == 6) ? 2'b11 : 2'b00);
    end

    for (int i = 0; i < 4000; i++) begin
      edge_();
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 1499) == 0) begin
        rst_n_i = 1'b0;
        edge_();
        edge_();
        rst_n_i = 1'b1;
      end
    end
    edge_();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
